// File: rtl/lab_pkg.sv
// lab_pkg: shared FSM state type and default screen geometry for the VGA lab
package lab_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} e_FSM_state;
  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COL_W = 3;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: column-major x/y scan counter, y inner, with end-of-screen flag
module raster_counter
  import lab_pkg::*;
#(
  parameter int W = SCR_W_DEF,
  parameter int H = SCR_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  localparam logic [X_W-1:0] X_MAX = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(H - 1);
  logic y_wrap;
  assign y_wrap = (y == Y_MAX);
  assign last = (x == X_MAX) && y_wrap;
  // step y every enabled cycle, carry into x on explicit wrap (never relies on overflow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      y <= y_wrap ? '0 : y + Y_W'(1);
      x <= y_wrap ? x + X_W'(1) : x;
    end
  end
endmodule

// File: rtl/fillscreen_plotter.sv
// fillscreen_plotter: plots every screen pixel exactly once in a latched colour on start/done handshake
module fillscreen_plotter
  import lab_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL_W-1:0] colour,
  input  logic             start,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output e_FSM_state       state
);
  e_FSM_state state_n;
  logic clr, en, last;
  raster_counter #(.W(SCR_W), .H(SCR_H)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .x    (vga_x),
    .y    (vga_y),
    .last (last)
  );
  // next state and counter control; the counter itself is the displayed pixel
  always_comb begin
    state_n = state;
    clr = 1'b0;
    en = 1'b0;
    case (state)
      S_IDLE: begin
        clr = start;
        state_n = start ? S_FILL : S_IDLE;
      end
      S_FILL: begin
        en = !last;
        state_n = last ? S_DONE : S_FILL;
      end
      S_DONE: state_n = start ? S_DONE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // state register, registered handshake/plot flags and colour latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done <= 1'b0;
      vga_plot <= 1'b0;
      vga_colour <= '0;
    end else begin
      state <= state_n;
      done <= (state_n == S_DONE);
      vga_plot <= (state_n == S_FILL);
      if (state == S_IDLE && start) vga_colour <= colour;
    end
  end
endmodule
